// File: rtl/seq_detect_param_if.sv
// Signal bundle between a serial source/consumer and the seq_detect_param detector.
interface seq_detect_param_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  localparam int SW = $clog2(N);

  logic             en;
  logic             x;
  logic             clr;
  logic             y;
  logic             y_q;
  logic [SW-1:0]    state_o;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output en, x, clr,
    input  y, y_q, state_o, match_cnt
  );

  modport slave (
    input  en, x, clr,
    output y, y_q, state_o, match_cnt
  );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised Mealy serial-pattern detector with registered pulse and saturating match counter.
// The transition table is computed from PATTERN during elaboration.
module seq_detect_param #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1010,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  seq_detect_param_if.slave  sif
);

  localparam int SW  = $clog2(N);
  localparam int NST = 1 << SW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Next state from Sk on bit xb: longest suffix of (prefix_k, xb) that is a proper prefix of
  // PATTERN. A full match falls out of the same search as the longest proper border.
  function automatic int next_fn(input int k, input int xb);
    logic [31:0] c;
    int          best;
    bit          ok;
    c = 32'd0;
    for (int i = 0; i < N; i++) begin
      if (i < k) begin
        c[i] = PATTERN[N-1-i];
      end
    end
    c[k] = xb[0];
    best = 0;
    if ((k == N - 1) && (c[k] == PATTERN[0]) && !OVERLAP) begin
      return 0;
    end
    for (int l = 1; l < N; l++) begin
      if (l <= k + 1) begin
        ok = 1'b1;
        for (int j = 0; j < N; j++) begin
          if (j < l) begin
            if (c[k+1-l+j] != PATTERN[N-1-j]) begin
              ok = 1'b0;
            end
          end
        end
        if (ok) begin
          best = l;
        end
      end
    end
    return best;
  endfunction

  logic [SW-1:0]    ns0_tbl [NST];
  logic [SW-1:0]    ns1_tbl [NST];
  logic [NST-1:0]   valid_tbl;

  for (genvar k = 0; k < NST; k++) begin : g_tbl
    if (k < N) begin : g_real
      localparam int NS0 = next_fn(k, 0);
      localparam int NS1 = next_fn(k, 1);
      assign ns0_tbl[k]   = SW'(NS0);
      assign ns1_tbl[k]   = SW'(NS1);
      assign valid_tbl[k] = 1'b1;
    end else begin : g_unreach
      assign ns0_tbl[k]   = '0;
      assign ns1_tbl[k]   = '0;
      assign valid_tbl[k] = 1'b0;
    end
  end

  logic [SW-1:0]    state_q, state_d;
  logic             y_q_q, y_q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit;

  // Mealy match, next state and counter update.
  always_comb begin
    hit     = sif.en & (state_q == SW'(N - 1)) & (sif.x == PATTERN[0]) & rst;
    state_d = state_q;
    y_q_d   = hit;
    cnt_d   = cnt_q;
    if (!valid_tbl[state_q]) begin
      state_d = '0;
    end else if (sif.en) begin
      state_d = sif.x ? ns1_tbl[state_q] : ns0_tbl[state_q];
    end else begin
      state_d = state_q;
    end
    // clr wins over a coincident match
    if (sif.clr) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, registered pulse and counter flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= '0;
      y_q_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q_q   <= y_q_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sif.y         = hit;
  assign sif.y_q       = y_q_q;
  assign sif.state_o   = state_q;
  assign sif.match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: four parameter variants, scoreboard of expected y_q/match_cnt.
module tb_seq_detect_param;

  logic clk;
  logic rst;

  seq_detect_param_if #(.N(4), .CNT_W(8)) if0 ();
  seq_detect_param_if #(.N(4), .CNT_W(8)) if1 ();
  seq_detect_param_if #(.N(4), .CNT_W(8)) if2 ();
  seq_detect_param_if #(.N(4), .CNT_W(2)) if3 ();

  seq_detect_param #(.N(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .CNT_W(8))
    u0 (.clk(clk), .rst(rst), .sif(if0));
  seq_detect_param #(.N(4), .PATTERN(4'b1010), .OVERLAP(1'b0), .CNT_W(8))
    u1 (.clk(clk), .rst(rst), .sif(if1));
  seq_detect_param #(.N(4), .PATTERN(4'b1110), .OVERLAP(1'b1), .CNT_W(8))
    u2 (.clk(clk), .rst(rst), .sif(if2));
  seq_detect_param #(.N(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .CNT_W(2))
    u3 (.clk(clk), .rst(rst), .sif(if3));

  typedef struct {
    int         d;
    logic       yq;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   exp_cnt [4];
  int   cnt_max [4];
  int   errors;
  int   checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int d, input bit e, input bit xv, input bit c);
    case (d)
      0: begin if0.en = e; if0.x = xv; if0.clr = c; end
      1: begin if1.en = e; if1.x = xv; if1.clr = c; end
      2: begin if2.en = e; if2.x = xv; if2.clr = c; end
      default: begin if3.en = e; if3.x = xv; if3.clr = c; end
    endcase
  endtask

  task automatic get_out(input int d, output logic oy, output logic oyq,
                         output logic [1:0] ost, output logic [7:0] ocnt);
    case (d)
      0: begin oy = if0.y; oyq = if0.y_q; ost = if0.state_o; ocnt = if0.match_cnt; end
      1: begin oy = if1.y; oyq = if1.y_q; ost = if1.state_o; ocnt = if1.match_cnt; end
      2: begin oy = if2.y; oyq = if2.y_q; ost = if2.state_o; ocnt = if2.match_cnt; end
      default: begin oy = if3.y; oyq = if3.y_q; ost = if3.state_o; ocnt = {6'd0, if3.match_cnt}; end
    endcase
  endtask

  task automatic chk_state(input int d, input logic [1:0] exp_st);
    logic oy, oyq;
    logic [1:0] ost;
    logic [7:0] ocnt;
    get_out(d, oy, oyq, ost, ocnt);
    chk($sformatf("d%0d state_o", d), {30'd0, ost}, {30'd0, exp_st});
  endtask

  // One accepted/ignored bit: check Mealy y, queue expected y_q/count, check them after the edge.
  task automatic step(input int d, input bit e, input bit xv, input bit c, input bit ey);
    exp_t       t;
    logic       oy, oyq;
    logic [1:0] ost;
    logic [7:0] ocnt;
    @(negedge clk);
    set_in(d, e, xv, c);
    #1;
    get_out(d, oy, oyq, ost, ocnt);
    chk($sformatf("d%0d y", d), {31'd0, oy}, {31'd0, ey});
    if (c) begin
      exp_cnt[d] = 0;
    end else if (ey && (exp_cnt[d] < cnt_max[d])) begin
      exp_cnt[d] = exp_cnt[d] + 1;
    end
    t.d   = d;
    t.yq  = ey;
    t.cnt = 8'(exp_cnt[d]);
    sb.push_back(t);
    @(posedge clk);
    #1;
    t = sb.pop_front();
    get_out(t.d, oy, oyq, ost, ocnt);
    chk($sformatf("d%0d y_q", t.d), {31'd0, oyq}, {31'd0, t.yq});
    chk($sformatf("d%0d match_cnt", t.d), {24'd0, ocnt}, {24'd0, t.cnt});
    set_in(d, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic       oy, oyq;
    logic [1:0] ost;
    logic [7:0] ocnt;
    errors  = 0;
    checks  = 0;
    exp_cnt = '{0, 0, 0, 0};
    cnt_max = '{255, 255, 255, 3};
    rst = 1'b0;
    for (int d = 0; d < 4; d++) set_in(d, 1'b0, 1'b0, 1'b0);

    // reset state
    #3;
    for (int d = 0; d < 4; d++) begin
      get_out(d, oy, oyq, ost, ocnt);
      chk($sformatf("d%0d rst y_q", d), {31'd0, oyq}, 32'd0);
      chk($sformatf("d%0d rst cnt", d), {24'd0, ocnt}, 32'd0);
      chk($sformatf("d%0d rst state", d), {30'd0, ost}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;

    // overlapping 1,0,1,0,1,0
    step(0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_state(0, 2'd2);

    // non-overlapping, same stream
    step(1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_state(1, 2'd2);

    // pattern 1110, stream 1,1,1,1,0
    step(2, 1'b1, 1'b1, 1'b0, 1'b0);
    step(2, 1'b1, 1'b1, 1'b0, 1'b0);
    step(2, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_state(2, 2'd3);
    step(2, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_state(2, 2'd3);
    step(2, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_state(2, 2'd0);

    // en gap inside the pattern (dut0 sits in S2: a 0 flushes to S0)
    step(0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_state(0, 2'd0);
    step(0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_state(0, 2'd3);
    step(0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_state(0, 2'd2);

    // asynchronous reset mid-pattern
    step(0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    set_in(0, 1'b1, 1'b0, 1'b0);
    #1;
    get_out(0, oy, oyq, ost, ocnt);
    chk("d0 pre-rst y", {31'd0, oy}, 32'd1);
    rst = 1'b0;
    #1;
    get_out(0, oy, oyq, ost, ocnt);
    chk("d0 async y", {31'd0, oy}, 32'd0);
    chk("d0 async y_q", {31'd0, oyq}, 32'd0);
    chk("d0 async cnt", {24'd0, ocnt}, 32'd0);
    chk("d0 async state", {30'd0, ost}, 32'd0);
    set_in(0, 1'b0, 1'b0, 1'b0);
    exp_cnt = '{0, 0, 0, 0};
    #1;
    rst = 1'b1;
    step(0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_state(0, 2'd0);

    // 2-bit counter saturation, then clr coinciding with a match
    step(3, 1'b1, 1'b1, 1'b0, 1'b0);
    step(3, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(3, 1'b1, 1'b1, 1'b0, 1'b0);
      step(3, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    step(3, 1'b1, 1'b1, 1'b0, 1'b0);
    step(3, 1'b1, 1'b0, 1'b1, 1'b1);
    chk_state(3, 2'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised Mealy serial-pattern detector: the generalised successor of the fixed 4-bit "1010" detector in the FSM library. It watches a 1-bit serial stream, qualified by a sample enable, for an arbitrary N-bit pattern. Matches are reported three ways: as a combinational Mealy pulse, as a registered pulse, and through a saturating match counter. Overlapping versus non-overlapping detection is selected by parameter. It sits between a serial receiver and control logic that reacts to sync/marker words.

## Interface
- N, default 4: pattern length in bits; legal range 2..16.
- PATTERN, default 4'b1010: N-bit pattern. PATTERN[N-1] is the first bit received, PATTERN[0] the last.
- OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping.
- CNT_W, default 8: width of the match counter; legal range 1..32.
- clk  input  1  sole clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  sample qualifier; x is consumed only on edges where en=1.
- x  input  1  serial data bit.
- clr  input  1  synchronous clear of match_cnt only.
- y  output  1  combinational Mealy match indication.
- y_q  output  1  y registered; 1-cycle pulse.
- state_o  output  ceil(log2(N))  current state, for debug.
- match_cnt  output  CNT_W  saturating count of matches.

## Operation
- States S0..S(N-1). Sk means k bits of the pattern prefix are currently matched. Precisely, Sk holds the longest suffix of the accepted bits (since reset or last non-overlap restart) that is a proper prefix of PATTERN. One state register, ceil(log2(N)) bits, binary encoded.
- Next state on an accepted bit, taken from state Sk with input x:
  - Let the candidate string be the k matched prefix bits followed by x.
  - If the candidate equals the full PATTERN, a match occurs:
    - OVERLAP=1: next state is Sb, where b is the longest proper border of PATTERN (a prefix that is also a suffix).
    - OVERLAP=0: next state is S0.
  - Otherwise, next state is S of the longest suffix of the candidate that is a proper prefix of PATTERN.
  - All transitions must be derived from PATTERN at elaboration time (generate or constant function). No hand-coded tables.
- For the default PATTERN, overlapping mode:
  - S0: x=1 goes to S1, x=0 stays S0.
  - S1: x=0 goes to S2, x=1 stays S1.
  - S2: x=1 goes to S3, x=0 goes to S0.
  - S3: x=0 is a match and goes to S2; x=1 goes to S1.
- en=0: state holds, y=0, no count.
- y = en & (state==S(N-1)) & (x==PATTERN[0]) & rst. Purely combinational, glitch-tolerant usage only.
- match_cnt:
  - Increments by 1 on each edge where y=1.
  - Saturates at 2^CNT_W-1.
  - clr=1 forces it to 0 on the edge; clr has priority over a simultaneous match.
  - clr does not affect state or y_q.
- Unreachable state encodings (N not a power of 2) go to S0 on the next edge regardless of en.

## Timing
- Reset (rst=0, asynchronous): state=S0, y_q=0, match_cnt=0, y=0 immediately. All take effect without a clock edge.
- Release: first bit sampled on the first rising edge with rst=1 and en=1.
- Reset asserted mid-pattern discards the partial match; no y_q pulse results.
- y latency: same cycle as the final pattern bit, with 0 edges.
- y_q latency: high for exactly the cycle following the edge that sampled the final bit.
- match_cnt latency: updates on the same edge as y_q.
- Back-to-back matches (OVERLAP=1 with a short border) produce consecutive y_q pulses with no gap required.
- en gaps inside a pattern are transparent: the bits need not be in consecutive cycles.

## Test plan
- Default params, stream 1,0,1,0,1,0 with en=1 -> y_q pulses after bits 4 and 6; match_cnt=2; state_o=2 at end.
- OVERLAP=0, same stream -> single y_q pulse after bit 4; match_cnt=1; state_o=2 at end.
- N=4, PATTERN=4'b1110, stream 1,1,1,1,0 -> state holds S3 on the 4th '1'; match after bit 5; match_cnt=1.
- Default params, bits 1,0,1 then en=0 for 3 cycles with x toggling, then 0 with en=1 -> no pulse during gap; one y_q after the final 0.
- Default params, 1,0,1 then rst pulsed low between edges, then 0 -> outputs 0 asynchronously; no match; state_o=0 after reset, then 0 after the 0.
- CNT_W=2, six overlapping matches -> match_cnt saturates at 3. Then clr=1 coinciding with a match -> match_cnt=0 and y_q=1.
